seq_gen: RTL and testbench

Serial test-pattern generator that drives the bit stream consumed by the board's sequence detector. It captures a programmable pattern of up to 16 bits and shifts it out MSB-first, one bit per prescaler period, on `x_out`. It can run once or loop continuously. It sits on the same fabric clock as the detector, with its output wired to the detector's `x` input, and shows the current bit index on the seven-segment display.

---
 rtl/seq_pkg.sv | 30 +++
 rtl/seg7_hex.sv | 31 +++
 rtl/seq_gen.sv | 159 +++++++++++++++
 tb/tb_seq_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and its hex display.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic IDLE_LVL = 1'b1;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex-to-seven-segment decoder, active-low outputs {a,b,c,d,e,f,g}.
module seg7_hex
  import seq_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_0;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seq_gen.sv
// Serial test-pattern generator: shifts a latched pattern out MSB-first, one bit per DIV clocks.
// Define SEQ_GEN_SEG_EN to build the registered seven-segment display of bit_idx.
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned DIV    = 20000000,
  parameter int unsigned MAXLEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [4:0]        len,
  input  logic              loop_en,
  output logic              x_out,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [3:0]        bit_idx,
  output logic [6:0]        seg
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PRELOAD = PW'(DIV - 1);

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [4:0]        len_q, len_d;
  logic              loop_q, loop_d;
  logic              stop_q, stop_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [3:0]        idx_q, idx_d;
  logic              x_q, x_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              stop_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      x_q     <= IDLE_LVL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      stop_q  <= stop_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    loop_d    = loop_q;
    stop_d    = stop_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    x_d       = x_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    stop_pend = stop_q | stop;

    case (state_q)
      IDLE: begin
        if (start && (len != 5'd0) && (len <= 5'(MAXLEN))) begin
          state_d = SHIFT;
          pat_d   = pattern;
          len_d   = len;
          loop_d  = loop_en;
          stop_d  = 1'b0;
          presc_d = PRELOAD;
          idx_d   = '0;
          x_d     = pattern[4'(len - 5'd1)];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        stop_d = stop_pend;
        if (presc_q != '0) begin
          presc_d = presc_q - PW'(1);
        end else if (stop_pend) begin
          state_d = DONE;
          stop_d  = 1'b0;
          x_d     = IDLE_LVL;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else if ({1'b0, idx_q} < (len_q - 5'd1)) begin
          // next bit is pattern[len-1-(idx+1)]
          idx_d   = idx_q + 4'd1;
          x_d     = pat_q[4'(len_q - 5'd2 - {1'b0, idx_q})];
          presc_d = PRELOAD;
        end else if (loop_q) begin
          idx_d   = '0;
          x_d     = pat_q[4'(len_q - 5'd1)];
          presc_d = PRELOAD;
        end else begin
          state_d = DONE;
          x_d     = IDLE_LVL;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign x_out   = x_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = idx_q;

`ifdef SEQ_GEN_SEG_EN
  logic [6:0] seg_d, seg_q;

  // Decode the next index so the display register lands in the same cycle as bit_idx.
  seg7_hex u_seg7_hex (
    .hex_i (idx_d),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) seg_q <= SEG_0;
    else     seg_q <= seg_d;
  end

  assign seg = seg_q;
`else
  assign seg = '1;
`endif

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen with DIV=4.
module tb_seq_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        loop_en;
  logic        x_out;
  logic        valid;
  logic        busy;
  logic        done;
  logic [3:0]  bit_idx;
  logic [6:0]  seg;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-written segment table, active-low {a..g}
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  // 16'h0005 with len 4 sent MSB-first
  logic bits_0101 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  // 16'hA5A5 sent MSB-first: 1010 0101 1010 0101
  logic bits_a5a5 [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                           1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  seq_gen #(.DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .pattern (pattern),
    .len     (len),
    .loop_en (loop_en),
    .x_out   (x_out),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .bit_idx (bit_idx),
    .seg     (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_exp(input int unsigned idx);
`ifdef SEQ_GEN_SEG_EN
    return seg_tab[idx];
`else
    return 7'b1111111;
`endif
  endfunction

  task automatic check_bit(input string tag, input logic exp_x, input int unsigned exp_idx);
    check({tag, ".x"},     x_out,   exp_x);
    check({tag, ".valid"}, valid,   1'b1);
    check({tag, ".busy"},  busy,    1'b1);
    check({tag, ".done"},  done,    1'b0);
    check({tag, ".idx"},   bit_idx, exp_idx);
    check({tag, ".seg"},   seg,     seg_exp(exp_idx));
  endtask

  task automatic check_done_cycle(input string tag);
    check({tag, ".done"},  done,  1'b1);
    check({tag, ".x1"},    x_out, 1'b1);
    check({tag, ".valid"}, valid, 1'b0);
    check({tag, ".busy"},  busy,  1'b1);
    @(negedge clk);
    check({tag, ".idle_busy"}, busy, 1'b0);
    check({tag, ".idle_done"}, done, 1'b0);
    check({tag, ".idle_x"},    x_out, 1'b1);
  endtask

  // 0101 run; optionally a second start with FFFF mid-run that must be ignored
  task automatic run_single(input string tag, input bit inject);
    pattern = 16'h0005; len = 5'd4; loop_en = 1'b0; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      check_bit(tag, bits_0101[(c - 1) / 4], (c - 1) / 4);
      if (inject && c == 6) begin
        start = 1'b1; pattern = 16'hFFFF; len = 5'd16; loop_en = 1'b1;
      end
      if (inject && c == 7) start = 1'b0;
    end
    @(negedge clk);
    check_done_cycle(tag);
    loop_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    pattern = '0; len = '0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.x",     x_out,   1'b1);
    check("rst.valid", valid,   1'b0);
    check("rst.busy",  busy,    1'b0);
    check("rst.done",  done,    1'b0);
    check("rst.idx",   bit_idx, 4'd0);
    check("rst.seg",   seg,     seg_exp(0));
    rst = 1'b0;
    @(negedge clk);

    run_single("single", 1'b0);
    repeat (2) @(negedge clk);
    run_single("busy_start", 1'b1);
    repeat (2) @(negedge clk);

    // Loop, then stop during bit 1 of the second pass
    pattern = 16'h0005; len = 5'd4; loop_en = 1'b1; start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      check_bit("loop", bits_0101[((c - 1) / 4) % 4], ((c - 1) / 4) % 4);
      if (c == 22) stop = 1'b1;
      if (c == 23) stop = 1'b0;
    end
    @(negedge clk);
    check_done_cycle("loop_stop");
    loop_en = 1'b0;
    repeat (2) @(negedge clk);

    // Invalid lengths: 0 and 17
    for (int k = 0; k < 2; k++) begin
      pattern = 16'h0005; len = (k == 0) ? 5'd0 : 5'd17; start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        check("badlen.busy",  busy,  1'b0);
        check("badlen.x",     x_out, 1'b1);
        check("badlen.done",  done,  1'b0);
        check("badlen.valid", valid, 1'b0);
      end
    end

    // Reset during bit 2
    pattern = 16'h0005; len = 5'd4; loop_en = 1'b0; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      check_bit("pre_rst", bits_0101[(c - 1) / 4], (c - 1) / 4);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst.x",     x_out,   1'b1);
    check("midrst.valid", valid,   1'b0);
    check("midrst.busy",  busy,    1'b0);
    check("midrst.done",  done,    1'b0);
    check("midrst.idx",   bit_idx, 4'd0);
    check("midrst.seg",   seg,     seg_exp(0));
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("postrst.done", done, 1'b0);
      check("postrst.busy", busy, 1'b0);
    end
    run_single("after_rst", 1'b0);
    repeat (2) @(negedge clk);

    // 16-bit run exercising every display digit
    pattern = 16'hA5A5; len = 5'd16; loop_en = 1'b0; start = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      check_bit("disp", bits_a5a5[(c - 1) / 4], (c - 1) / 4);
    end
    @(negedge clk);
    check_done_cycle("disp");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
